systolic_feeder: RTL and testbench

// - Upstream stage of the systolic array: sequences one tile of work into it.
// - Preloads ARRAY_N weight rows through b_path / b_path_en, then pulses b_en to latch them.
// - Streams num_vec input vectors with a diagonal skew (lane n delayed n cycles).
// - Flushes the array with zeros and reports done; valid/ready on both input streams.

---
 rtl/systolic_feeder_pkg.sv | 27 ++
 rtl/systolic_feeder_if.sv | 42 ++++
 rtl/systolic_feeder_skew.sv | 30 +++
 rtl/systolic_feeder.sv | 117 +++++++++++
 tb/tb_systolic_feeder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types and widths for the systolic array datapath: feeder FSM states
// and the default tile geometry used by the feeder, the array and the collector.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LATCH,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_e;

    localparam int ARRAY_M_DEF        = 8;
    localparam int ARRAY_N_DEF        = 8;
    localparam int INP_DATA_WIDTH_DEF = 8;
    localparam int WGT_DATA_WIDTH_DEF = 8;
    localparam int K_MAX_DEF          = 256;

    // Accumulator width leaves headroom for ARRAY_N products summed down a column.
    localparam int PE_OUT_WIDTH = INP_DATA_WIDTH_DEF + WGT_DATA_WIDTH_DEF + $clog2(ARRAY_N_DEF);

    function automatic int clamp_count(input int n, input int lim);
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and array-side bus of the systolic feeder; slave is the feeder's view,
// master is the view of whatever drives tiles into it.
interface systolic_feeder_if
    import sa_pkg::*;
#(
    parameter int ARRAY_M        = ARRAY_M_DEF,
    parameter int ARRAY_N        = ARRAY_N_DEF,
    parameter int INP_DATA_WIDTH = INP_DATA_WIDTH_DEF,
    parameter int WGT_DATA_WIDTH = WGT_DATA_WIDTH_DEF,
    parameter int K_MAX          = K_MAX_DEF
);
    localparam int CNT_W = $clog2(K_MAX + 1);

    logic                                start;
    logic [CNT_W-1:0]                    num_vec;
    logic                                wgt_valid;
    logic                                wgt_ready;
    logic [ARRAY_M*WGT_DATA_WIDTH-1:0]   wgt_data;
    logic                                inp_valid;
    logic                                inp_ready;
    logic [ARRAY_N*INP_DATA_WIDTH-1:0]   inp_data;
    logic [ARRAY_N*INP_DATA_WIDTH-1:0]   sa_inp;
    logic [ARRAY_M*WGT_DATA_WIDTH-1:0]   sa_wgt;
    logic [ARRAY_N-1:0]                  sa_b_path_en;
    logic [ARRAY_N-1:0]                  sa_b_en;
    logic [ARRAY_N-1:0]                  sa_lane_vld;
    logic                                busy;
    logic                                done;

    modport slave (
        input  start, num_vec, wgt_valid, wgt_data, inp_valid, inp_data,
        output wgt_ready, inp_ready, sa_inp, sa_wgt, sa_b_path_en, sa_b_en,
               sa_lane_vld, busy, done
    );

    modport master (
        output start, num_vec, wgt_valid, wgt_data, inp_valid, inp_data,
        input  wgt_ready, inp_ready, sa_inp, sa_wgt, sa_b_path_en, sa_b_en,
               sa_lane_vld, busy, done
    );

endinterface

// File: rtl/systolic_feeder_skew.sv
// Per-lane skew line: DEPTH register stages carrying {vld, data}; the last stage
// is the registered lane output.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (shift_en_i) begin
            stage_q[0] <= {vld_i, data_i};
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign vld_o  = stage_q[DEPTH-1][WIDTH];
    assign data_o = stage_q[DEPTH-1][WIDTH-1:0];

endmodule

// File: rtl/systolic_feeder.sv
// Tile sequencer for the systolic array: loads ARRAY_N weight rows, latches them,
// streams num_vec diagonally skewed input vectors, flushes with zeros, pulses done.
module systolic_feeder
    import sa_pkg::*;
#(
    parameter int ARRAY_M        = ARRAY_M_DEF,
    parameter int ARRAY_N        = ARRAY_N_DEF,
    parameter int INP_DATA_WIDTH = INP_DATA_WIDTH_DEF,
    parameter int WGT_DATA_WIDTH = WGT_DATA_WIDTH_DEF,
    parameter int K_MAX          = K_MAX_DEF,
    parameter int CNT_W          = $clog2(K_MAX + 1),
    parameter int DRAIN_CYC      = ARRAY_M + ARRAY_N - 1
) (
    input  logic             clk,
    input  logic             reset,
    systolic_feeder_if.slave bus
);

    localparam int W_CNT_W = $clog2(ARRAY_N + 1);
    localparam int D_CNT_W = $clog2(DRAIN_CYC + 1);

    feeder_state_e                     state_q, state_d;
    logic [W_CNT_W-1:0]                w_cnt_q;
    logic [CNT_W-1:0]                  vec_cnt_q;
    logic [CNT_W-1:0]                  num_vec_q;
    logic [D_CNT_W-1:0]                drain_cnt_q;
    logic [ARRAY_M*WGT_DATA_WIDTH-1:0] sa_wgt_q;
    logic [ARRAY_N-1:0]                b_path_en_q;
    logic [ARRAY_N-1:0]                b_en_q;

    logic wgt_fire, inp_fire, last_wgt, last_vec, drain_tc, shift_en;
    logic [ARRAY_N-1:0]                lane_vld;
    logic [ARRAY_N*INP_DATA_WIDTH-1:0] lane_data;

    assign bus.wgt_ready = (state_q == LOAD_W);
    assign bus.inp_ready = (state_q == STREAM) && (vec_cnt_q < num_vec_q);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

    assign wgt_fire = bus.wgt_valid & bus.wgt_ready;
    assign inp_fire = bus.inp_valid & bus.inp_ready;
    assign last_wgt = (w_cnt_q == W_CNT_W'(ARRAY_N - 1));
    assign last_vec = ((vec_cnt_q + CNT_W'(1)) == num_vec_q);
    assign drain_tc = (drain_cnt_q == '0);
    assign shift_en = (state_q == STREAM) || (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD_W;
            LOAD_W:  if (wgt_fire && last_wgt) state_d = LATCH;
            LATCH:   state_d = (num_vec_q != '0) ? STREAM : DONE;
            STREAM:  if (inp_fire && last_vec) state_d = DRAIN;
            DRAIN:   if (drain_tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            w_cnt_q     <= '0;
            vec_cnt_q   <= '0;
            num_vec_q   <= '0;
            drain_cnt_q <= '0;
            sa_wgt_q    <= '0;
            b_path_en_q <= '0;
            b_en_q      <= '0;
        end else begin
            state_q     <= state_d;
            b_path_en_q <= wgt_fire ? '1 : '0;
            // b_en trails the last weight-shift cycle so the array sees shift, then latch.
            b_en_q      <= (state_q == LATCH) ? '1 : '0;

            if (state_q == IDLE && bus.start) begin
                num_vec_q <= CNT_W'(clamp_count(int'(bus.num_vec), K_MAX));
                w_cnt_q   <= '0;
                vec_cnt_q <= '0;
            end

            if (wgt_fire) begin
                sa_wgt_q <= bus.wgt_data;
                if (w_cnt_q != W_CNT_W'(ARRAY_N)) w_cnt_q <= w_cnt_q + W_CNT_W'(1);
            end

            if (inp_fire) vec_cnt_q <= vec_cnt_q + CNT_W'(1);

            if (state_q == STREAM && state_d == DRAIN)
                drain_cnt_q <= D_CNT_W'(DRAIN_CYC - 1);
            else if (state_q == DRAIN && !drain_tc)
                drain_cnt_q <= drain_cnt_q - D_CNT_W'(1);
        end
    end

    for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
        skew_delay_line #(
            .DEPTH (n + 1),
            .WIDTH (INP_DATA_WIDTH)
        ) u_skew (
            .clk        (clk),
            .reset      (reset),
            .shift_en_i (shift_en),
            .vld_i      (inp_fire),
            .data_i     (inp_fire ? bus.inp_data[n*INP_DATA_WIDTH +: INP_DATA_WIDTH] : '0),
            .vld_o      (lane_vld[n]),
            .data_o     (lane_data[n*INP_DATA_WIDTH +: INP_DATA_WIDTH])
        );
    end

    assign bus.sa_inp       = lane_data;
    assign bus.sa_lane_vld  = lane_vld;
    assign bus.sa_wgt       = sa_wgt_q;
    assign bus.sa_b_path_en = b_path_en_q;
    assign bus.sa_b_en      = b_en_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a cycle-level reference of the tile sequence feeds
// per-lane and weight scoreboards that are checked against the array-side bus.
module tb_systolic_feeder;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int IW = 8;
    localparam int WW = 8;
    localparam int KM = 16;
    localparam int DC = M + N - 1;

    typedef enum int {P_IDLE, P_LOAD, P_LATCH, P_STREAM, P_DRAIN, P_DONE} phase_t;
    typedef struct { int due; logic [M*WW-1:0] d; } wq_t;
    typedef struct { int due; logic [IW-1:0]   d; } lq_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if #(.ARRAY_M(M), .ARRAY_N(N), .INP_DATA_WIDTH(IW),
                         .WGT_DATA_WIDTH(WW), .K_MAX(KM)) bus ();

    systolic_feeder #(.ARRAY_M(M), .ARRAY_N(N), .INP_DATA_WIDTH(IW),
                      .WGT_DATA_WIDTH(WW), .K_MAX(KM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    phase_t          ph = P_IDLE;
    int              m_nv, m_wc, m_vc, m_dc;
    int              b_en_due = -1;
    int              n_done = 0;
    int              n_acc  = 0;
    logic [M*WW-1:0] last_wgt = '0;
    wq_t             wq[$];
    lq_t             lq[N][$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [N-1:0]    exp_vld;
        logic [N*IW-1:0] exp_inp;
        logic [N-1:0]    ones;
        wq_t             we;
        lq_t             le;
        ones = '1;

        if (reset) begin
            ph = P_IDLE;
            wq.delete();
            for (int n = 0; n < N; n++) lq[n].delete();
            last_wgt = '0;
            b_en_due = -1;
        end

        check_eq("busy",      bus.busy,      ph != P_IDLE);
        check_eq("done",      bus.done,      ph == P_DONE);
        check_eq("wgt_ready", bus.wgt_ready, ph == P_LOAD);
        check_eq("inp_ready", bus.inp_ready, ph == P_STREAM);
        if (bus.done) n_done++;

        if (wq.size() > 0 && wq[0].due == cyc) begin
            we = wq.pop_front();
            last_wgt = we.d;
            check_eq("b_path_en_shift", bus.sa_b_path_en, ones);
            check_eq("sa_wgt_row",      bus.sa_wgt,       we.d);
        end else begin
            check_eq("b_path_en_idle", bus.sa_b_path_en, '0);
            check_eq("sa_wgt_hold",    bus.sa_wgt,       last_wgt);
        end
        check_eq("b_en", bus.sa_b_en, (b_en_due == cyc) ? ones : '0);

        exp_vld = '0;
        exp_inp = '0;
        for (int n = 0; n < N; n++) begin
            if (lq[n].size() > 0 && lq[n][0].due == cyc) begin
                le = lq[n].pop_front();
                exp_vld[n] = 1'b1;
                exp_inp[n*IW +: IW] = le.d;
            end
        end
        check_eq("lane_vld", bus.sa_lane_vld, exp_vld);
        check_eq("sa_inp",   bus.sa_inp,      exp_inp);

        if (!reset) begin
            case (ph)
                P_IDLE: if (bus.start) begin
                    m_nv = (int'(bus.num_vec) > KM) ? KM : int'(bus.num_vec);
                    m_wc = 0;
                    m_vc = 0;
                    n_acc++;
                    ph = P_LOAD;
                end
                P_LOAD: if (bus.wgt_valid) begin
                    we.due = cyc + 1;
                    we.d   = bus.wgt_data;
                    wq.push_back(we);
                    m_wc++;
                    if (m_wc == N) begin
                        b_en_due = cyc + 2;
                        ph = P_LATCH;
                    end
                end
                P_LATCH: ph = (m_nv > 0) ? P_STREAM : P_DONE;
                P_STREAM: if (bus.inp_valid) begin
                    for (int n = 0; n < N; n++) begin
                        le.due = cyc + n + 1;
                        le.d   = bus.inp_data[n*IW +: IW];
                        lq[n].push_back(le);
                    end
                    m_vc++;
                    if (m_vc == m_nv) begin
                        m_dc = 0;
                        ph = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    m_dc++;
                    if (m_dc == DC) ph = P_DONE;
                end
                P_DONE: ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nv);
        bus.start   = 1'b1;
        bus.num_vec = 5'(nv);
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic load_weights(input int gap_row, input bit spam);
        for (int r = 0; r < N; r++) begin
            int g = 0;
            bus.wgt_data  = $urandom;
            bus.wgt_valid = 1'b1;
            if (spam) bus.start = 1'b1;
            while (!bus.wgt_ready && g < 64) begin tick(); g++; end
            check_eq("wgt_ready_wait", bus.wgt_ready, 1'b1);
            tick();
            if (r == gap_row) begin
                bus.wgt_valid = 1'b0;
                repeat (3) tick();
            end
        end
        bus.wgt_valid = 1'b0;
    endtask

    task automatic stream(input int n_send, input int bub_vec, input bit spam);
        for (int v = 0; v < n_send; v++) begin
            int g = 0;
            bus.inp_data  = $urandom;
            bus.inp_valid = 1'b1;
            if (spam) bus.start = 1'b1;
            while (!bus.inp_ready && g < 64) begin tick(); g++; end
            check_eq("inp_ready_wait", bus.inp_ready, 1'b1);
            tick();
            if (v == bub_vec) begin
                bus.inp_valid = 1'b0;
                tick();
            end
        end
        bus.inp_valid = 1'b0;
    endtask

    // With spam set, start stays high through the DONE cycle and drops in the IDLE cycle after.
    task automatic wait_done(input bit spam);
        int g = 0;
        if (spam) bus.start = 1'b1;
        while (!bus.done && g < 200) begin tick(); g++; end
        check_eq("done_wait", bus.done, 1'b1);
        tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic run_tile(input int nv, input int n_send, input int gap_row,
                            input int bub_vec, input bit spam);
        do_start(nv);
        load_weights(gap_row, spam);
        stream(n_send, bub_vec, spam);
        wait_done(spam);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.num_vec   = '0;
        bus.wgt_valid = 1'b0;
        bus.wgt_data  = '0;
        bus.inp_valid = 1'b0;
        bus.inp_data  = '0;
        #1 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        run_tile(2, 2, -1, -1, 1'b0);    // back-to-back rows and vectors
        run_tile(2, 2,  1,  0, 1'b0);    // 3-cycle weight stall, one input bubble
        run_tile(0, 0, -1, -1, 1'b0);    // empty tile: LATCH straight to DONE
        run_tile(3, 3,  2,  1, 1'b1);    // start held high while busy and in DONE

        do_start(5);                     // reset lands in STREAM with three vectors taken
        load_weights(-1, 1'b0);
        stream(3, -1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        run_tile(3, 3, -1, 2, 1'b0);
        run_tile(20, KM, -1, -1, 1'b0);  // num_vec above K_MAX clamps

        repeat (4) tick();
        check_eq("start_count", n_acc, 7);
        check_eq("done_count", n_done, n_acc - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
